// File: rtl/snes_pad_mux.sv
// SNES controller-side serialiser with an N-way button-source multiplexer.
// Optional feature: define SNES_PAD_MUX_STICKY_EN to latch short presses until the next poll.
module snes_pad_mux #(
    parameter int NUM_SRC   = 4,
    parameter int BTN_W     = 12,
    parameter int FRAME_LEN = 16,
    parameter int SEL_W     = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SRC*BTN_W-1:0] src_data,
    input  logic [NUM_SRC-1:0]       src_valid,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     snes_latch,
    input  logic                     snes_clk,
    output logic                     snes_data,
    output logic [SEL_W-1:0]         active_src,
    output logic                     frame_done,
    output logic [7:0]               frame_cnt
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [FRAME_LEN-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]             frame_cnt_q, frame_cnt_d;
    logic [SEL_W-1:0]       active_src_q, active_src_d;
    logic                   frame_done_q, frame_done_d;

    logic                   latch_meta_q, latch_s_q;
    logic                   clk_meta_q, clk_s_q, clk_prev_q, clk_rise_q;

    logic [BTN_W-1:0]       btn;
    logic [BTN_W-1:0]       btn_load;
    logic [FRAME_LEN-1:0]   load_val;

    // The console clock idles high, so its synchroniser resets high to avoid a phantom rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            latch_meta_q <= 1'b0;
            latch_s_q    <= 1'b0;
            clk_meta_q   <= 1'b1;
            clk_s_q      <= 1'b1;
            clk_prev_q   <= 1'b1;
            clk_rise_q   <= 1'b0;
        end else begin
            latch_meta_q <= snes_latch;
            latch_s_q    <= latch_meta_q;
            clk_meta_q   <= snes_clk;
            clk_s_q      <= clk_meta_q;
            clk_prev_q   <= clk_s_q;
            clk_rise_q   <= clk_s_q & ~clk_prev_q;
        end
    end

    // Out-of-range or invalid selections read as all buttons released.
    always_comb begin
        btn = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (src_valid[s] && (sel == SEL_W'(s))) begin
                btn = src_data[s*BTN_W +: BTN_W];
            end
        end
    end

`ifdef SNES_PAD_MUX_STICKY_EN
    logic [BTN_W-1:0] sticky_q, sticky_d;

    always_comb begin
        btn_load = btn | sticky_q;
        sticky_d = sticky_q;
        if (state_q == LOAD) begin
            if (!latch_s_q) begin
                sticky_d = '0;
            end
        end else begin
            sticky_d = sticky_q | btn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end
`else
    always_comb begin
        btn_load = btn;
    end
`endif

    always_comb begin
        load_val                = '1;
        load_val[BTN_W-1:0]     = ~btn_load;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shreg_q      <= '1;
            bit_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            active_src_q <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            active_src_q <= active_src_d;
            frame_done_q <= frame_done_d;
        end
    end

    // A high latch overrides everything, including a clock edge seen in the same cycle.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        active_src_d = active_src_q;
        frame_done_d = 1'b0;

        if (latch_s_q) begin
            state_d      = LOAD;
            shreg_d      = load_val;
            active_src_d = sel;
        end else begin
            case (state_q)
                LOAD: begin
                    state_d     = SHIFT;
                    bit_cnt_d   = '0;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
                SHIFT: begin
                    if (clk_rise_q) begin
                        shreg_d   = {1'b1, shreg_q[FRAME_LEN-1:1]};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                            state_d      = DONE;
                            frame_done_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    assign snes_data  = shreg_q[0];
    assign active_src = active_src_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_snes_pad_mux.sv
// Directed bench for snes_pad_mux: polls the pad like a console and checks each captured frame.
// A second instance with three sources covers the out-of-range select case.
module tb_snes_pad_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] srcData;
    logic [3:0]  srcValid;
    logic [35:0] srcData3;
    logic [2:0]  srcValid3;
    logic [1:0]  sel;
    logic        snesLatch;
    logic        snesClk;

    logic        snesData, snesData3;
    logic [1:0]  activeSrc, activeSrc3;
    logic        frameDone, frameDone3;
    logic [7:0]  frameCnt, frameCnt3;

    int total     = 0;
    int bad       = 0;
    int doneCount = 0;
    int expDone   = 0;
    int expFrames = 0;

    logic [15:0] line, line3;

    always #5 clk = ~clk;

    snes_pad_mux #(.NUM_SRC(4), .BTN_W(12), .FRAME_LEN(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_data   (srcData),
        .src_valid  (srcValid),
        .sel        (sel),
        .snes_latch (snesLatch),
        .snes_clk   (snesClk),
        .snes_data  (snesData),
        .active_src (activeSrc),
        .frame_done (frameDone),
        .frame_cnt  (frameCnt)
    );

    snes_pad_mux #(.NUM_SRC(3), .BTN_W(12), .FRAME_LEN(16)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .src_data   (srcData3),
        .src_valid  (srcValid3),
        .sel        (sel),
        .snes_latch (snesLatch),
        .snes_clk   (snesClk),
        .snes_data  (snesData3),
        .active_src (activeSrc3),
        .frame_done (frameDone3),
        .frame_cnt  (frameCnt3)
    );

    always @(negedge clk) begin
        if (frameDone) doneCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One console poll: latch pulse, then nClk clock pulses; each bit is sampled before its rising clock.
    task automatic applyStimulus(input int nClk, input int changeAt, input logic [1:0] newSel,
                                 output logic [15:0] bits, output logic [15:0] bits3);
        bits  = '1;
        bits3 = '1;
        @(negedge clk);
        snesLatch = 1'b1;
        repeat (4) @(negedge clk);
        snesLatch = 1'b0;
        expFrames++;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nClk; i++) begin
            if (i == changeAt) sel = newSel;
            bits[i]  = snesData;
            bits3[i] = snesData3;
            snesClk = 1'b0;
            repeat (3) @(negedge clk);
            snesClk = 1'b1;
            repeat (6) @(negedge clk);
        end
    endtask

    initial begin
        rst       = 1'b1;
        srcData   = '0;
        srcValid  = '0;
        srcData3  = {3{12'hFFF}};
        srcValid3 = 3'b111;
        sel       = 2'd0;
        snesLatch = 1'b0;
        snesClk   = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        checkOutput("rst_data", snesData, 1'b1);
        checkOutput("rst_cnt", frameCnt, 8'd0);
        checkOutput("rst_active", activeSrc, 2'd0);
        checkOutput("rst_done", doneCount, 0);

        // B button only on source 1
        sel = 2'd1;
        srcValid = 4'b0010;
        srcData[12 +: 12] = 12'h001;
        applyStimulus(16, -1, 2'd0, line, line3);
        expDone++;
        checkOutput("b_only", line, 16'hFFFE);
        checkOutput("b_only_3src", line3, 16'hF000);
        checkOutput("b_only_done", doneCount, expDone);
        checkOutput("b_only_cnt", frameCnt, expFrames);
        checkOutput("b_only_active", activeSrc, 2'd1);

        // Clocks after the frame are ignored
        snesClk = 1'b0;
        repeat (3) @(negedge clk);
        snesClk = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("done_idle_data", snesData, 1'b1);
        checkOutput("done_idle_pulse", doneCount, expDone);

        // Invalid source reads released, then valid source reads pressed
        sel = 2'd2;
        srcData[24 +: 12] = 12'hFFF;
        applyStimulus(16, -1, 2'd0, line, line3);
        expDone++;
        checkOutput("invalid_src", line, 16'hFFFF);
        srcValid = 4'b0110;
        applyStimulus(16, -1, 2'd0, line, line3);
        expDone++;
        checkOutput("valid_src2", line, 16'hF000);
        checkOutput("valid_src2_done", doneCount, expDone);

        // Out of range select on the three-source instance
        sel = 2'd3;
        applyStimulus(16, -1, 2'd0, line, line3);
        expDone++;
        checkOutput("out_of_range", line3, 16'hFFFF);
        checkOutput("invalid_src3", line, 16'hFFFF);

        // Mixed pattern from source 0
        sel = 2'd0;
        srcValid = 4'b1111;
        srcData[0 +: 12] = 12'hA5C;
        applyStimulus(16, -1, 2'd0, line, line3);
        expDone++;
        checkOutput("pattern", line, 16'hF5A3);

        // Abort after five clocks, then a full frame
        applyStimulus(5, -1, 2'd0, line, line3);
        checkOutput("abort_partial", line[4:0], 5'b00011);
        applyStimulus(16, -1, 2'd0, line, line3);
        expDone++;
        checkOutput("after_abort", line, 16'hF5A3);
        checkOutput("abort_done", doneCount, expDone);
        checkOutput("abort_cnt", frameCnt, expFrames);

        // Select change mid-frame does not take effect until the next latch
        srcData[0 +: 12]  = 12'h0F0;
        srcData[36 +: 12] = 12'hFFF;
        applyStimulus(16, 5, 2'd3, line, line3);
        expDone++;
        checkOutput("sel_midframe", line, 16'hFF0F);
        checkOutput("sel_mid_active", activeSrc, 2'd0);
        applyStimulus(16, -1, 2'd0, line, line3);
        expDone++;
        checkOutput("sel_next", line, 16'hF000);
        checkOutput("sel_next_active", activeSrc, 2'd3);

        // Short press between polls
        sel = 2'd0;
        srcData[0 +: 12] = 12'h000;
        applyStimulus(16, -1, 2'd0, line, line3);
        expDone++;
        srcData[4] = 1'b1;
        repeat (10) @(negedge clk);
        srcData[4] = 1'b0;
        applyStimulus(16, -1, 2'd0, line, line3);
        expDone++;
`ifdef SNES_PAD_MUX_STICKY_EN
        checkOutput("sticky_1", line, 16'hFFEF);
`else
        checkOutput("sticky_1", line, 16'hFFFF);
`endif
        applyStimulus(16, -1, 2'd0, line, line3);
        expDone++;
        checkOutput("sticky_2", line, 16'hFFFF);
        checkOutput("final_done", doneCount, expDone);
        checkOutput("final_cnt", frameCnt, expFrames);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
